// File: rtl/serial_mag_compare_ctrl_pkg.sv
// Shared types and constants for the serial two-bit-per-cycle magnitude comparator.
// Holds the controller state encoding, the slice result encoding and the default width.
package serial_mag_compare_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    S_GT = 2'b00,
    S_EQ = 2'b01,
    S_LT = 2'b10
  } slice_res_t;

endpackage

// File: rtl/serial_mag_compare_ctrl_cmp2_slice.sv
// Combinational 2-bit unsigned compare slice with one-hot gt/eq/lt outputs.
// This is the single compare resource shared across all slices by the controller.
module cmp2_slice
  import serial_mag_compare_ctrl_pkg::*;
(
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic       o_gt,
  output logic       o_eq,
  output logic       o_lt
);

  slice_res_t w_res;

  always_comb begin
    if (i_a > i_b)      w_res = S_GT;
    else if (i_a < i_b) w_res = S_LT;
    else                w_res = S_EQ;
  end

  always_comb begin
    o_gt = (w_res == S_GT);
    o_eq = (w_res == S_EQ);
    o_lt = (w_res == S_LT);
  end

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Sequenced magnitude comparator: walks operand pairs MSB slice first, two bits per
// cycle, stopping on the first unequal slice and pulsing done with the registered result.
module serial_mag_compare_ctrl
  import serial_mag_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start,
  input  logic [WIDTH-1:0]               i_a,
  input  logic [WIDTH-1:0]               i_b,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_gt,
  output logic                           o_eq,
  output logic                           o_lt,
  output logic [$clog2(WIDTH/2):0]       o_nslices
);

  localparam int NSL  = WIDTH / 2;
  localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int CNTW = $clog2(NSL) + 1;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [IDXW-1:0]   r_idx;
  logic [CNTW-1:0]   r_cnt;
  logic              r_gt;
  logic              r_eq;
  logic              r_lt;
  logic [CNTW-1:0]   r_nslices;
  logic [1:0]        w_sa;
  logic [1:0]        w_sb;
  logic              w_gt;
  logic              w_eq;
  logic              w_lt;
  logic              w_last;

  // Slice mux: select the operand pair addressed by the down-counting index.
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int i = 0; i < NSL; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_sa = r_a[2*i +: 2];
        w_sb = r_b[2*i +: 2];
      end
    end
  end

  assign w_last = (r_idx == '0);

  cmp2_slice u_slice (
    .i_a  (w_sa),
    .i_b  (w_sb),
    .o_gt (w_gt),
    .o_eq (w_eq),
    .o_lt (w_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_next = SCAN;
      SCAN:    if (!w_eq || w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (r_state != IDLE);
    o_done    = (r_state == DONE);
    o_gt      = r_gt;
    o_eq      = r_eq;
    o_lt      = r_lt;
    o_nslices = r_nslices;
  end

  // Results are cleared on accept and only rewritten on the deciding slice, so they
  // hold steady through DONE and the following idle period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_gt      <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
      r_nslices <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_a       <= i_a;
      r_b       <= i_b;
      r_idx     <= IDXW'(NSL - 1);
      r_cnt     <= '0;
      r_gt      <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
      r_nslices <= '0;
    end else if (r_state == SCAN) begin
      r_cnt <= r_cnt + 1'b1;
      if (!w_eq) begin
        r_gt      <= w_gt;
        r_lt      <= w_lt;
        r_nslices <= r_cnt + 1'b1;
      end else if (w_last) begin
        r_eq      <= 1'b1;
        r_nslices <= CNTW'(NSL);
      end else begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Self-checking bench for serial_mag_compare_ctrl (WIDTH=8): table-driven vectors scored
// through a queue popped on done, plus hand-written multi-cycle corner sequences.
module tb_serial_mag_compare_ctrl;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       gt;
    logic       eq;
    logic       lt;
    logic [2:0] ns;
  } vec_t;

  typedef struct {
    logic       gt;
    logic       eq;
    logic       lt;
    logic [2:0] ns;
    int         c0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       o_busy;
  logic       o_done;
  logic       o_gt;
  logic       o_eq;
  logic       o_lt;
  logic [2:0] o_nslices;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   doneCount = 0;
  bit   sbEnable = 1'b1;
  exp_t sbq[$];
  vec_t vecs[11];

  serial_mag_compare_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_gt      (o_gt),
    .o_eq      (o_eq),
    .o_lt      (o_lt),
    .o_nslices (o_nslices)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every done pops one expectation, including the start-to-done latency.
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      doneCount++;
      if (sbEnable) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("gt", int'(o_gt), int'(e.gt));
          checkOutput("eq", int'(o_eq), int'(e.eq));
          checkOutput("lt", int'(o_lt), int'(e.lt));
          checkOutput("nslices", int'(o_nslices), int'(e.ns));
          checkOutput("latency", cyc - e.c0, int'(e.ns));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic gt,
                               input logic eq, input logic lt, input logic [2:0] ns,
                               input bit push);
    exp_t e;
    @(negedge clk);
    i_a = a;
    i_b = b;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("busy_after_accept", int'(o_busy), 1);
    checkOutput("flags_cleared", int'({o_gt, o_eq, o_lt}), 0);
    checkOutput("nslices_cleared", int'(o_nslices), 0);
    if (push) begin
      e.gt = gt; e.eq = eq; e.lt = lt; e.ns = ns; e.c0 = cyc;
      sbq.push_back(e);
    end
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic waitIdle();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (!o_busy) seen = 1'b1;
    end
    if (!seen) checkOutput("idle_timeout", 1, 0);
  endtask

  initial begin
    int  d0;
    bit  dn[15];
    bit  bz[15];
    int  f;

    vecs[0]  = '{8'hA5, 8'h35, 1'b1, 1'b0, 1'b0, 3'd1};
    vecs[1]  = '{8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 3'd4};
    vecs[2]  = '{8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 3'd4};
    vecs[3]  = '{8'h40, 8'h80, 1'b0, 1'b0, 1'b1, 3'd1};
    vecs[4]  = '{8'h03, 8'h02, 1'b1, 1'b0, 1'b0, 3'd4};
    vecs[5]  = '{8'hC0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd1};
    vecs[6]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd1};
    vecs[7]  = '{8'h34, 8'h38, 1'b0, 1'b0, 1'b1, 3'd3};
    vecs[8]  = '{8'h0C, 8'h08, 1'b1, 1'b0, 1'b0, 3'd3};
    vecs[9]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4};
    vecs[10] = '{8'h27, 8'h17, 1'b1, 1'b0, 1'b0, 3'd2};

    rst_n = 1'b0;
    i_start = 1'b0;
    i_a = 8'h00;
    i_b = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(o_busy), 0);
    checkOutput("reset_done", int'(o_done), 0);
    checkOutput("reset_flags", int'({o_gt, o_eq, o_lt}), 0);
    checkOutput("reset_nslices", int'(o_nslices), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].gt, vecs[i].eq, vecs[i].lt, vecs[i].ns, 1'b1);
      waitIdle();
    end

    // EQ result must hold through a long idle stretch.
    applyStimulus(8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1);
    waitIdle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_flags", int'({o_gt, o_eq, o_lt}), 3'b010);
      checkOutput("hold_nslices", int'(o_nslices), 4);
      checkOutput("hold_done", int'(o_done), 0);
    end

    // Operand isolation: live a change and a repeated start mid-SCAN are both ignored.
    d0 = doneCount;
    applyStimulus(8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
    i_a = 8'hFF;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    waitIdle();
    repeat (4) @(negedge clk);
    checkOutput("isolation_done_count", doneCount - d0, 1);
    checkOutput("isolation_idle", int'(o_busy), 0);

    // Asynchronous reset mid-SCAN discards the compare.
    d0 = doneCount;
    applyStimulus(8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", int'(o_busy), 0);
    checkOutput("midreset_done", int'(o_done), 0);
    checkOutput("midreset_flags", int'({o_gt, o_eq, o_lt}), 0);
    checkOutput("midreset_nslices", int'(o_nslices), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("midreset_no_done", doneCount - d0, 0);
    applyStimulus(8'h03, 8'h02, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1);
    waitIdle();

    // start held high: back-to-back one-slice compares every 3 cycles.
    sbEnable = 1'b0;
    @(negedge clk);
    i_a = 8'hC0;
    i_b = 8'h00;
    i_start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      dn[i] = o_done;
      bz[i] = o_busy;
      if (o_done) begin
        checkOutput("held_gt", int'(o_gt), 1);
        checkOutput("held_nslices", int'(o_nslices), 1);
      end
    end
    i_start = 1'b0;
    f = -1;
    for (int i = 0; i < 6; i++) if (f < 0 && dn[i]) f = i;
    if (f < 0) begin
      checkOutput("held_first_done", 0, 1);
    end else begin
      for (int i = f; i < f + 9; i++) begin
        checkOutput("held_done_pattern", int'(dn[i]), int'(((i - f) % 3) == 0));
        checkOutput("held_busy_pattern", int'(bz[i]), int'(((i - f) % 3) != 1));
      end
    end
    waitIdle();
    repeat (2) @(negedge clk);
    sbEnable = 1'b1;

    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
